// File: rtl/sdram_resp_checker.sv
// sdram_resp_checker
// Streaming read-response checker sitting behind the SDRAM driver response
// port. After a start pulse it consumes n_bursts_i bursts of BURST_LEN words,
// compares each word against base + global word index, checks last framing,
// counts errors (saturating) and records the first failing word.
//
// Optional feature macro: SDRAM_CHK_TIMEOUT_EN (idle-cycle timeout in RUN).
//
// Ports:
//   clk_axi, rstn_axi         clock, async active-low reset
//   start_i                   start pulse (taken in IDLE or DONE)
//   pattern_base_i            expected value of word 0, latched at start
//   n_bursts_i                bursts to check, latched at start
//   stall_i                   forces resp_ready_o low
//   resp_valid_i/last_i/data_i response stream in
//   resp_ready_o              checker accepts a word this cycle
//   busy_o                    high in RUN
//   done_o                    one-cycle pulse on entering DONE
//   pass_o                    in DONE: no errors and no timeout
//   err_cnt_o                 data + framing errors, saturating
//   first_err_idx_o/data_o    word index / received data of first error
//   burst_cnt_o               completed bursts
//   timeout_o                 run ended by timeout
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | consuming and checking response words
// DONE  | results held until next start
module sdram_resp_checker #(
  parameter int DATA_W      = 16,
  parameter int BURST_LEN   = 8,
  parameter int NBURST_W    = 16,
  parameter int ERR_CNT_W   = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk_axi,
  input  logic                 rstn_axi,
  input  logic                 start_i,
  input  logic [DATA_W-1:0]    pattern_base_i,
  input  logic [NBURST_W-1:0]  n_bursts_i,
  input  logic                 stall_i,
  input  logic                 resp_valid_i,
  input  logic                 resp_last_i,
  input  logic [DATA_W-1:0]    resp_data_i,
  output logic                 resp_ready_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [31:0]          first_err_idx_o,
  output logic [DATA_W-1:0]    first_err_data_o,
  output logic [NBURST_W-1:0]  burst_cnt_o,
  output logic                 timeout_o
);

  localparam int BEAT_W = (BURST_LEN > 2) ? $clog2(BURST_LEN) : 1;

  if (BURST_LEN < 2 || TIMEOUT_CYC < 1) begin : g_param_check
    $error("sdram_resp_checker: BURST_LEN must be >= 2 and TIMEOUT_CYC >= 1");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
  state_t state, next_state;

  logic                enter_done;
  logic                start_take;
  logic                accept;
  logic                last_beat;
  logic                final_word;
  logic                timeout_hit;
  logic                data_err;
  logic                frame_err;
  logic [DATA_W-1:0]   expected;
  logic [DATA_W-1:0]   base_q;
  logic [NBURST_W-1:0] nb_q;
  logic [31:0]         word_idx;
  logic [BEAT_W-1:0]   beat;
  logic                have_err;
  logic                done_q;

  assign start_take = start_i && (state != ST_RUN);
  assign accept     = resp_valid_i && resp_ready_o;
  assign last_beat  = (beat == BEAT_W'(BURST_LEN - 1));
  assign final_word = accept && last_beat &&
                      ((burst_cnt_o + NBURST_W'(1)) == nb_q);
  assign expected   = base_q + DATA_W'(word_idx);
  assign data_err   = (resp_data_i != expected);
  assign frame_err  = (resp_last_i != last_beat);

`ifdef SDRAM_CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            idle_cyc;
  logic            timeout_q;

  // Stalled cycles neither count nor clear: the bench throttle is not the
  // driver's fault.
  assign idle_cyc    = (state == ST_RUN) && !stall_i && !accept;
  assign timeout_hit = idle_cyc && (idle_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign timeout_o   = timeout_q;

  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (start_take || accept) idle_cnt <= '0;
      else if (idle_cyc)        idle_cnt <= idle_cnt + TO_W'(1);
      if (start_take)           timeout_q <= 1'b0;
      else if (timeout_hit)     timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) state <= ST_IDLE;
    else           state <= next_state;
  end

  always_comb begin
    next_state = state;
    enter_done = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          if (n_bursts_i == '0) begin
            next_state = ST_DONE;
            enter_done = 1'b1;
          end else begin
            next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (final_word || timeout_hit) begin
          next_state = ST_DONE;
          enter_done = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state == ST_RUN);
    resp_ready_o = (state == ST_RUN) && !stall_i;
    done_o       = done_q;
    pass_o       = (state == ST_DONE) && (err_cnt_o == '0) && !timeout_o;
  end

  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      done_q           <= 1'b0;
      base_q           <= '0;
      nb_q             <= '0;
      word_idx         <= '0;
      beat             <= '0;
      burst_cnt_o      <= '0;
      err_cnt_o        <= '0;
      have_err         <= 1'b0;
      first_err_idx_o  <= '0;
      first_err_data_o <= '0;
    end else begin
      done_q <= enter_done;
      if (start_take) begin
        base_q           <= pattern_base_i;
        nb_q             <= n_bursts_i;
        word_idx         <= '0;
        beat             <= '0;
        burst_cnt_o      <= '0;
        err_cnt_o        <= '0;
        have_err         <= 1'b0;
        first_err_idx_o  <= '0;
        first_err_data_o <= '0;
      end else if (accept) begin
        word_idx <= word_idx + 32'd1;
        // Burst boundary follows the internal beat count, never resp_last_i.
        if (last_beat) begin
          beat        <= '0;
          burst_cnt_o <= burst_cnt_o + NBURST_W'(1);
        end else begin
          beat <= beat + BEAT_W'(1);
        end
        if (data_err || frame_err) begin
          if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
          if (!have_err) begin
            have_err         <= 1'b1;
            first_err_idx_o  <= word_idx;
            first_err_data_o <= resp_data_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_resp_checker.sv
module tb_sdram_resp_checker;

  logic        clk_axi = 1'b0;
  logic        rstn_axi;
  logic        start_i;
  logic [15:0] pattern_base_i;
  logic [15:0] n_bursts_i;
  logic        stall_i;
  logic        resp_valid_i;
  logic        resp_last_i;
  logic [15:0] resp_data_i;
  logic        resp_ready_o;
  logic        busy_o;
  logic        done_o;
  logic        pass_o;
  logic [15:0] err_cnt_o;
  logic [31:0] first_err_idx_o;
  logic [15:0] first_err_data_o;
  logic [15:0] burst_cnt_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_axi = ~clk_axi;

  sdram_resp_checker #(
    .DATA_W(16), .BURST_LEN(8), .NBURST_W(16), .ERR_CNT_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .clk_axi(clk_axi), .rstn_axi(rstn_axi), .start_i(start_i),
    .pattern_base_i(pattern_base_i), .n_bursts_i(n_bursts_i), .stall_i(stall_i),
    .resp_valid_i(resp_valid_i), .resp_last_i(resp_last_i), .resp_data_i(resp_data_i),
    .resp_ready_o(resp_ready_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .err_cnt_o(err_cnt_o), .first_err_idx_o(first_err_idx_o),
    .first_err_data_o(first_err_data_o), .burst_cnt_o(burst_cnt_o), .timeout_o(timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " ready"}, {31'd0, resp_ready_o}, 32'd0);
    check({tag, " busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, " done"}, {31'd0, done_o}, 32'd0);
    check({tag, " pass"}, {31'd0, pass_o}, 32'd0);
    check({tag, " err_cnt"}, {16'd0, err_cnt_o}, 32'd0);
    check({tag, " first_idx"}, first_err_idx_o, 32'd0);
    check({tag, " first_data"}, {16'd0, first_err_data_o}, 32'd0);
    check({tag, " burst_cnt"}, {16'd0, burst_cnt_o}, 32'd0);
    check({tag, " timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  // Start pulse in one cycle; returns at the negedge of the following cycle
  // (checker already in RUN or DONE).
  task automatic start_run(input logic [15:0] base, input logic [15:0] n);
    @(negedge clk_axi);
    start_i = 1'b1; pattern_base_i = base; n_bursts_i = n;
    @(negedge clk_axi);
    start_i = 1'b0; pattern_base_i = 16'h0; n_bursts_i = 16'h0;
  endtask

  // Ideal driver with optional corruption. Returns at the negedge just after
  // the last word was accepted.
  task automatic drive_words(input logic [15:0] base, input int nwords,
                             input int bad_idx, input logic [15:0] bad_val,
                             input int last_on, input int last_off,
                             input bit toggle_stall, input string tag);
    int w = 0;
    int cyc = 0;
    logic acc;
    while (w < nwords && cyc < nwords * 4 + 20) begin
      stall_i      = toggle_stall ? cyc[0] : 1'b0;
      resp_valid_i = 1'b1;
      resp_data_i  = (w == bad_idx) ? bad_val : base + w[15:0];
      resp_last_i  = (w % 8 == 7);
      if (w == last_on)  resp_last_i = 1'b1;
      if (w == last_off) resp_last_i = 1'b0;
      #1;
      if (toggle_stall) check({tag, " ready follows stall"}, {31'd0, resp_ready_o}, {31'd0, !stall_i});
      acc = resp_ready_o;
      @(negedge clk_axi);
      if (acc) w++;
      cyc++;
    end
    resp_valid_i = 1'b0; resp_last_i = 1'b0; stall_i = 1'b0;
    check({tag, " words accepted"}, w, nwords);
  endtask

  task automatic check_done(input string tag, input bit exp_pass, input logic [15:0] exp_err,
                            input logic [15:0] exp_bursts);
    check({tag, " done pulse"}, {31'd0, done_o}, 32'd1);
    check({tag, " busy low"}, {31'd0, busy_o}, 32'd0);
    check({tag, " pass"}, {31'd0, pass_o}, {31'd0, exp_pass});
    check({tag, " err_cnt"}, {16'd0, err_cnt_o}, {16'd0, exp_err});
    check({tag, " burst_cnt"}, {16'd0, burst_cnt_o}, {16'd0, exp_bursts});
    resp_valid_i = 1'b1;  // stray word in DONE must not be accepted
    #1;
    check({tag, " ready low in DONE"}, {31'd0, resp_ready_o}, 32'd0);
    @(negedge clk_axi);
    resp_valid_i = 1'b0;
    check({tag, " done one cycle"}, {31'd0, done_o}, 32'd0);
    check({tag, " pass stable"}, {31'd0, pass_o}, {31'd0, exp_pass});
  endtask

  initial begin
    rstn_axi = 1'b0; start_i = 1'b0; pattern_base_i = 16'h0; n_bursts_i = 16'h0;
    stall_i = 1'b0; resp_valid_i = 1'b0; resp_last_i = 1'b0; resp_data_i = 16'h0;
    #22;
    check_all_zero("reset");
    @(negedge clk_axi);
    rstn_axi = 1'b1;
    @(negedge clk_axi);

    // Clean run: 4 bursts from 0x1234
    start_run(16'h1234, 16'd4);
    check("run_a busy", {31'd0, busy_o}, 32'd1);
    drive_words(16'h1234, 32, -1, 16'h0, -1, -1, 1'b0, "run_a");
    check("run_a first_idx", first_err_idx_o, 32'd0);
    check("run_a timeout", {31'd0, timeout_o}, 32'd0);
    check_done("run_a", 1'b1, 16'd0, 16'd4);

    // Word 11 corrupted
    start_run(16'h1234, 16'd4);
    drive_words(16'h1234, 32, 11, 16'hDEAD, -1, -1, 1'b0, "run_b");
    check("run_b first_idx", first_err_idx_o, 32'd11);
    check("run_b first_data", {16'd0, first_err_data_o}, 32'h0000DEAD);
    check_done("run_b", 1'b0, 16'd1, 16'd4);

    // Early last on beat 5, missing last on beat 7; burst still 8 words
    start_run(16'h0100, 16'd1);
    drive_words(16'h0100, 8, -1, 16'h0, 5, 7, 1'b0, "run_c");
    check("run_c first_idx", first_err_idx_o, 32'd5);
    check("run_c first_data", {16'd0, first_err_data_o}, 32'h00000105);
    check_done("run_c", 1'b0, 16'd2, 16'd1);

    // Pattern wraps past 0xFFFF
    start_run(16'hFFFC, 16'd1);
    drive_words(16'hFFFC, 8, -1, 16'h0, -1, -1, 1'b0, "run_d");
    check_done("run_d", 1'b1, 16'd0, 16'd1);

    // Same with stall toggling every other cycle
    start_run(16'hFFFC, 16'd1);
    drive_words(16'hFFFC, 8, -1, 16'h0, -1, -1, 1'b1, "run_e");
    check_done("run_e", 1'b1, 16'd0, 16'd1);

    // Zero bursts: done one cycle after start
    start_run(16'h5555, 16'd0);
    check_done("zero", 1'b1, 16'd0, 16'd0);

    // Reset mid-run after 3 words
    start_run(16'h0000, 16'd2);
    drive_words(16'h0000, 3, -1, 16'h0, -1, -1, 1'b0, "abort");
    check("abort busy before reset", {31'd0, busy_o}, 32'd1);
    rstn_axi = 1'b0;
    #1;
    check_all_zero("abort");
    @(negedge clk_axi);
    rstn_axi = 1'b1;
    repeat (2) @(negedge clk_axi);
    check("abort no done", {31'd0, done_o}, 32'd0);
    check("abort idle", {31'd0, busy_o}, 32'd0);

    // Driver silent after 3 words
    start_run(16'h0040, 16'd2);
    drive_words(16'h0040, 3, -1, 16'h0, -1, -1, 1'b0, "silent");
`ifdef SDRAM_CHK_TIMEOUT_EN
    begin
      int k = 0;
      while (!done_o && k < 100) begin
        @(negedge clk_axi);
        k++;
      end
      check("timeout cycles after last accept", k, 16);
      check("timeout flag", {31'd0, timeout_o}, 32'd1);
      check_done("timeout", 1'b0, 16'd0, 16'd0);
    end
`else
    repeat (40) @(negedge clk_axi);
    check("silent still busy", {31'd0, busy_o}, 32'd1);
    check("silent no done", {31'd0, done_o}, 32'd0);
    check("silent timeout tied low", {31'd0, timeout_o}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_resp_checker.md
# sdram_resp_checker

Streaming read-response checker placed directly downstream of the SDRAM driver's response port (`resp_valid`/`resp_last`/`resp_data`/`resp_ready`). After a start pulse it consumes a programmed number of fixed-length bursts and compares every word against an incrementing pattern (`base + global word index`). It also checks `last` framing, counts errors, and records the first failure. Results feed the board status LEDs and the simulation benches.

## Interface

Parameters:

- `DATA_W`, 16, response data width
- `BURST_LEN`, 8, words per burst (≥2)
- `NBURST_W`, 16, width of burst-count input
- `ERR_CNT_W`, 16, error counter width (saturating)
- `TIMEOUT_CYC`, 1024, idle-cycle limit (used only with `SDRAM_CHK_TIMEOUT_EN`)

Ports:

- `clk_axi` in 1: single clock; all logic is on its rising edge
- `rstn_axi` in 1: asynchronous, active-low reset
- `start_i` in 1: single-cycle start pulse; sampled only in IDLE or DONE
- `pattern_base_i` in DATA_W: expected value of word 0; sampled at start
- `n_bursts_i` in NBURST_W: number of bursts to check; sampled at start
- `stall_i` in 1: bench throttle; forces `resp_ready_o` low
- `resp_valid_i` in 1: response word valid
- `resp_last_i` in 1: last word of burst
- `resp_data_i` in DATA_W: response word
- `resp_ready_o` out 1: checker accepts a word
- `busy_o` out 1: high in RUN
- `done_o` out 1: one-cycle pulse on entering DONE
- `pass_o` out 1: valid in DONE; 1 iff `err_cnt_o==0` and no timeout
- `err_cnt_o` out ERR_CNT_W: data plus framing errors, saturating
- `first_err_idx_o` out 32: global word index of the first error
- `first_err_data_o` out DATA_W: received data at the first error
- `burst_cnt_o` out NBURST_W: completed bursts
- `timeout_o` out 1: run ended by timeout (constant 0 when the feature is disabled)

## Operation

- States: IDLE, RUN, DONE.
  - IDLE→RUN on `start_i`.
  - RUN→DONE after the final burst completes, or on timeout.
  - DONE→RUN on `start_i`.
  - `start_i` is ignored in RUN.
- At start:
  - Latch base and burst count.
  - Clear `word_idx`, `beat_in_burst`, `burst_cnt_o`, `err_cnt_o`, `first_err_*`, `timeout_o`.
  - If `n_bursts_i==0`, go to DONE instead of RUN, with `pass_o=1`.
- `resp_ready_o = (state==RUN) && !stall_i`. This is combinational. Accept = `resp_valid_i && resp_ready_o`.
- On each accepted word:
  - Expected value = `(base + word_idx) mod 2^DATA_W`, truncating addition.
  - Data error if `resp_data_i != expected`.
  - Framing error if `resp_last_i != (beat_in_burst==BURST_LEN-1)`.
  - A word with both a data error and a framing error counts as one error.
  - On the first error only, capture `word_idx` and `resp_data_i`.
  - `err_cnt_o` saturates at all-ones.
  - Burst boundary is decided by the internal `beat_in_burst` counter, not by `resp_last_i`.
  - At `beat_in_burst==BURST_LEN-1`: wrap `beat_in_burst` to 0 and increment `burst_cnt_o`. If `burst_cnt_o+1 == n_bursts`, go to DONE.
  - `word_idx` is 32 bits and wraps.
- Words presented outside RUN are not accepted (ready low). Stray responses are never consumed.
- Reset values of all outputs: 0. State is IDLE.
- Reset asserted mid-run aborts immediately and returns to IDLE. No `done_o` pulse is produced.

## Timing

- Zero-cycle ready: an acceptance in cycle N updates the counters and error registers at edge N+1.
- Final word accepted at cycle N: state is DONE at N+1, `done_o=1` for cycle N+1 only, and `resp_ready_o` is low from N+1.
- `pass_o`, `err_cnt_o` and `first_err_*` are stable from N+1 until the next start or reset.
- `start_i` at cycle S: `busy_o` and `resp_ready_o` go high from S+1 (ready subject to `stall_i`).
- With `n_bursts_i==0`: `done_o` pulses at S+1.
- Maximum throughput: one word per clock.

## Configuration

- `SDRAM_CHK_TIMEOUT_EN` defined:
  - A counter counts RUN cycles with no accepted word. Cycles with `stall_i` high are not counted and hold the counter.
  - The counter resets on every acceptance.
  - When it reaches `TIMEOUT_CYC`, go to DONE with `timeout_o=1`, `pass_o=0`, and pulse `done_o`.
- Not defined: no counter logic; `timeout_o` is tied to 0. A missing response stalls in RUN indefinitely.

## Test plan

- Base 0x1234, `n_bursts_i=4`, BURST_LEN=8, ideal driver → 32 words accepted, `done_o` pulse, `pass_o=1`, `err_cnt_o=0`, `burst_cnt_o=4`.
- Same run but word 11 corrupted to 0xDEAD → `err_cnt_o=1`, `first_err_idx_o=11`, `first_err_data_o=0xDEAD`, `pass_o=0`.
- `resp_last_i` asserted on beat 5 of burst 0 and missing on beat 7 → `err_cnt_o=2`, `first_err_idx_o=5`. The burst still ends after 8 words.
- Base 0xFFFC, 1 burst → expected sequence FFFC, FFFD, FFFE, FFFF, 0000 … 0003; `pass_o=1`. Separately, `stall_i` toggled every other cycle → `resp_ready_o` follows; same pass result.
- `n_bursts_i=0` → `done_o` one cycle after start, `pass_o=1`. Separately, `rstn_axi` pulsed after 3 words → all outputs 0, IDLE, no `done_o`.
- `SDRAM_CHK_TIMEOUT_EN` with `TIMEOUT_CYC=16`, driver silent after 3 words → DONE 16 cycles after the last accept, `timeout_o=1`, `pass_o=0`.
